// File: rtl/prbs_pkg.sv
// prbs_pkg: shared mode/state encodings and LFSR tap positions for the PRBS pattern generator.
package prbs_pkg;

    typedef enum logic [1:0] {PRBS7, PRBS15, PRBS23, PRBS31} prbs_mode_e;

    typedef enum logic [1:0] {IDLE, HEADER, PRBS} state_e;

    localparam int LFSR_W = 31;

    // Tap bit indices (tap - 1); tap_a + 1 is also the register length L for the mode.
    function automatic logic [4:0] tap_a(prbs_mode_e m);
        return m == PRBS7 ? 5'd6 : m == PRBS15 ? 5'd14 : m == PRBS23 ? 5'd22 : 5'd30;
    endfunction

    function automatic logic [4:0] tap_b(prbs_mode_e m);
        return m == PRBS7 ? 5'd5 : m == PRBS15 ? 5'd13 : m == PRBS23 ? 5'd17 : 5'd27;
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// prbs_lfsr: Fibonacci LFSR producing OUT_W consecutive generated bits per beat, first bit in the MSB.
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  prbs_mode_e       mode,
    input  logic             load,
    input  logic             advance,
    output logic [OUT_W-1:0] data
);

    logic [LFSR_W-1:0] s, s_nxt;
    logic [4:0]        ta, tb;

    // Shifting the full 31-bit register is harmless for shorter modes: taps never reach above L-1.
    always_comb begin
        ta    = tap_a(mode);
        tb    = tap_b(mode);
        s_nxt = s;
        data  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            data  = {data[OUT_W-2:0], s_nxt[ta] ^ s_nxt[tb]};
            s_nxt = {s_nxt[LFSR_W-2:0], data[0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s <= '1;
        else if (load)
            s <= '1;
        else if (advance)
            s <= s_nxt;
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// prbs_pattern_gen: emits n_repeats copies of a header pattern followed by prbs_len PRBS beats,
// with valid/ready handshake, frame-end marker and abort.
module prbs_pattern_gen
    import prbs_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int PAT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [7:0]       n_repeats,
    input  logic [CNT_W-1:0] prbs_len,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int NB = PAT_W / OUT_W;
    localparam int SW = NB > 1 ? $clog2(NB) : 1;

    state_e           state, state_n;
    prbs_mode_e       mode_q;
    logic [PAT_W-1:0] hdr_sh;
    logic [7:0]       rep_left;
    logic [SW-1:0]    slice;
    logic [CNT_W-1:0] prbs_left;
    logic [OUT_W-1:0] lfsr_data;
    logic             xfer, slice_end, hdr_end, accept, load;

    assign xfer      = out_valid && out_ready;
    assign slice_end = slice == SW'(NB - 1);
    assign hdr_end   = slice_end && rep_left == 8'd1;
    assign accept    = state == IDLE && start && (n_repeats != 8'd0 || prbs_len != '0);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        if (abort)
            state_n = IDLE;
        else
            case (state)
                IDLE:
                    if (accept) begin
                        state_n = n_repeats != 8'd0 ? HEADER : PRBS;
                        load    = n_repeats == 8'd0;
                    end
                HEADER:
                    if (xfer && hdr_end) begin
                        state_n = prbs_left != '0 ? PRBS : IDLE;
                        load    = prbs_left != '0;
                    end
                PRBS:
                    if (xfer && prbs_left == CNT_W'(1))
                        state_n = IDLE;
                default:
                    state_n = IDLE;
            endcase
    end

    // Header is rotated one slice per transfer so the current slice always sits in the MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= PRBS7;
            hdr_sh    <= '0;
            rep_left  <= '0;
            slice     <= '0;
            prbs_left <= '0;
        end else begin
            state <= state_n;
            if (!abort) begin
                if (accept) begin
                    mode_q    <= prbs_mode_e'(mode);
                    hdr_sh    <= pattern_in;
                    rep_left  <= n_repeats;
                    slice     <= '0;
                    prbs_left <= prbs_len;
                end else if (xfer && state == HEADER) begin
                    hdr_sh   <= (hdr_sh << OUT_W) | (hdr_sh >> (PAT_W - OUT_W));
                    slice    <= slice_end ? '0 : slice + 1'b1;
                    rep_left <= slice_end ? rep_left - 8'd1 : rep_left;
                end else if (xfer && state == PRBS) begin
                    prbs_left <= prbs_left - CNT_W'(1);
                end
            end
        end
    end

    prbs_lfsr #(.OUT_W(OUT_W)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode_q),
        .load   (load),
        .advance(xfer && state == PRBS && !abort),
        .data   (lfsr_data)
    );

    assign out_valid = state != IDLE;
    assign busy      = state != IDLE;
    assign out_data  = state == HEADER ? hdr_sh[PAT_W-1 -: OUT_W] : state == PRBS ? lfsr_data : '0;
    assign out_last  = (state == HEADER && hdr_end && prbs_left == '0) ||
                       (state == PRBS && prbs_left == CNT_W'(1));

endmodule

// File: doc/prbs_pattern_gen.md
PRBS_PATTERN_GEN -- requirements
Module: prbs_pattern_gen

Interface
REQ-001 Parameter OUT_W, default 8: output beat width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 Parameter PAT_W, default 32: header pattern width in bits; it SHALL be a multiple of OUT_W.
REQ-003 Parameter CNT_W, default 16: width of the PRBS beat-length counter.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle request to begin a frame.
REQ-007 abort  in  1  synchronous frame termination.
REQ-008 mode  in  2  polynomial select: 00 = PRBS7 (x^7+x^6+1), 01 = PRBS15 (x^15+x^14+1), 10 = PRBS23 (x^23+x^18+1), 11 = PRBS31 (x^31+x^28+1).
REQ-009 pattern_in  in  PAT_W  header pattern.
REQ-010 n_repeats  in  8  number of header repetitions.
REQ-011 prbs_len  in  CNT_W  number of PRBS beats.
REQ-012 out_data  out  OUT_W  beat data, first-generated bit in the MSB.
REQ-013 out_valid  out  1  beat valid.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 out_last  out  1  marks the final beat of a frame.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, HEADER, PRBS.
- IDLE -> HEADER on start when n_repeats != 0.
- IDLE -> PRBS on start when n_repeats == 0 and prbs_len != 0.
- start when both counts are zero: ignored.
REQ-018 mode, pattern_in, n_repeats and prbs_len are latched at the accepted start; later input changes have no effect on the frame.
REQ-019 start while busy is ignored.
REQ-020 out_valid asserts the cycle after an accepted start and stays high until the frame ends.
REQ-021 A beat transfers only when out_valid && out_ready; out_data and out_last are held stable while stalled.
REQ-022 HEADER emits PAT_W/OUT_W beats per repetition, MSB slice first, n_repeats times, then PRBS (if prbs_len != 0) or IDLE.
REQ-023 LFSR per step (Fibonacci, length L):
- Taps tA/tB = 7/6, 15/14, 23/18, 31/28 per mode.
- b = s[tA-1] ^ s[tB-1]; s <= {s[L-2:0], b}; b is the generated bit.
REQ-024 On entry to PRBS, the LFSR is seeded all-ones; each PRBS beat consumes OUT_W consecutive steps, with the first step in the MSB.
REQ-025 The LFSR advances only on a transferred PRBS beat.
REQ-026 out_last is high on the final beat of the frame:
- the last PRBS beat; or
- the last header beat when prbs_len == 0.
REQ-027 After the last beat transfers, the FSM returns to IDLE and out_valid drops the next cycle.
REQ-028 abort in any state:
- forces IDLE next cycle and clears out_valid and out_last;
- a pending beat is discarded;
- abort has priority over start and over the handshake.
REQ-029 Counters SHALL NOT wrap: n_repeats = 255 and prbs_len = 2^CNT_W-1 are emitted exactly.

Reset
REQ-030 While rst_n is low, the block SHALL be in this state:
- FSM = IDLE;
- out_data = 0, out_valid = 0, out_last = 0, busy = 0;
- LFSR = all-ones;
- all counters = 0.
REQ-031 Reset assertion mid-frame aborts immediately; no beat completes in the reset cycle.

Structure
REQ-032 A shared package prbs_pkg SHALL hold:
- the mode encoding enum;
- the tap/length constants per mode;
- the FSM state enum.
REQ-033 The LFSR SHALL be a sub-module, prbs_lfsr, with ports:
- parameters OUT_W and mode;
- load (seed) and advance;
- an OUT_W-bit parallel output.

Verification
REQ-034 OUT_W=8, pattern_in=32'hA5C3_0F96, n_repeats=2, prbs_len=0, ready=1 -> beats A5,C3,0F,96,A5,C3,0F,96; out_last on the 8th beat; busy low after.
REQ-035 mode=00, n_repeats=0, prbs_len=2, OUT_W=8 -> first beat 8'h02; the second beat matches the reference model; out_last on beat 2.
REQ-036 Backpressure: toggle out_ready randomly during a PRBS15 frame of 100 beats -> the sequence is identical to the ready=1 run, and no data changes while valid && !ready.
REQ-037 abort asserted on the 3rd beat of a header -> out_valid low the next cycle, then busy=0; a new start gives a fresh frame with LFSR reseeded.
REQ-038 start with n_repeats=0 and prbs_len=0 -> no out_valid, busy stays 0; start while busy -> frame unaffected.
REQ-039 rst_n low mid-PRBS31 frame -> all outputs 0 asynchronously; after release, a start gives the seed-derived first beat.
